// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter sharing a single-port register file between the system
// controller (port 0) and the configuration/debug master (port 1).
module rf_access_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_TIMEOUT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  output logic                  gnt0,
  output logic [DATA_WIDTH-1:0] rd_data0,
  output logic                  rd_valid0,
  output logic                  rd_err0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt1,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic                  rd_valid1,
  output logic                  rd_err1,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic                  busy
);

  localparam int CNT_WIDTH = $clog2(RD_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  state_t                state, state_next;
  logic                  owner, last;
  logic                  cmd_we;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  take, take_owner;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  rd_done, rd_timeout, rd_finish;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    take       = 1'b0;
    take_owner = last;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 && req1) begin
          take       = 1'b1;
          take_owner = ~last;
        end else if (req0) begin
          take       = 1'b1;
          take_owner = 1'b0;
        end else if (req1) begin
          take       = 1'b1;
          take_owner = 1'b1;
        end
        if (take) state_next = ISSUE;
      end
      ISSUE: state_next = cmd_we ? IDLE : WAIT_RD;
      WAIT_RD: begin
        // Valid wins over a timeout landing in the same cycle.
        if (RdData_Valid) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          rd_timeout = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    sel_we    = take_owner ? we1    : we0;
    sel_addr  = take_owner ? addr1  : addr0;
    sel_wdata = take_owner ? wdata1 : wdata0;
    rd_finish = rd_done | rd_timeout;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      owner     <= 1'b0;
      last      <= 1'b1;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      wr_data_q <= '0;
      cnt       <= '0;
      rd_data0  <= '0;
      rd_valid0 <= 1'b0;
      rd_err0   <= 1'b0;
      rd_data1  <= '0;
      rd_valid1 <= 1'b0;
      rd_err1   <= 1'b0;
    end else begin
      state     <= state_next;
      rd_valid0 <= 1'b0;
      rd_err0   <= 1'b0;
      rd_valid1 <= 1'b0;
      rd_err1   <= 1'b0;

      if (take) begin
        owner     <= take_owner;
        last      <= take_owner;
        cmd_we    <= sel_we;
        cmd_addr  <= sel_addr;
        wr_data_q <= sel_we ? sel_wdata : '0;
      end

      if (state == ISSUE)        cnt <= '0;
      else if (state == WAIT_RD) cnt <= cnt + 1'b1;

      if (rd_finish) begin
        if (!owner) begin
          rd_valid0 <= 1'b1;
          rd_err0   <= rd_timeout;
          rd_data0  <= rd_timeout ? '0 : RdData;
        end else begin
          rd_valid1 <= 1'b1;
          rd_err1   <= rd_timeout;
          rd_data1  <= rd_timeout ? '0 : RdData;
        end
      end
    end
  end

  // Bus outputs are decoded from registered state only.
  assign gnt0    = (state == ISSUE) && !owner;
  assign gnt1    = (state == ISSUE) &&  owner;
  assign WrEn    = (state == ISSUE) &&  cmd_we;
  assign RdEn    = (state == ISSUE) && !cmd_we;
  assign Address = cmd_addr;
  assign WrData  = wr_data_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Randomized bench for rf_access_arbiter; expected bus activity is planned per
// transaction (issue cycle, wait length, return cycle) from the access rules.
module tb_rf_access_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int T  = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, rd_valid0, rd_err0, gnt1, rd_valid1, rd_err1;
  logic [DW-1:0] rd_data0, rd_data1;
  logic [AW-1:0] Address;
  logic          WrEn, RdEn, busy;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData = '0;
  logic          RdData_Valid = 1'b0;

  always #5 CLK = ~CLK;

  rf_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(T)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rd_data0(rd_data0), .rd_valid0(rd_valid0), .rd_err0(rd_err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rd_data1(rd_data1), .rd_valid1(rd_valid1), .rd_err1(rd_err1),
    .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .busy(busy)
  );

  // lat: cycles from RdEn to RdData_Valid; 0 means the register file never answers.
  typedef struct {
    int            owner;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] rdata;
    int            start;
    int            issue;
    int            busy_end;
    int            rdv;
    bit            err;
  } txn_t;

  txn_t          txq[$];
  txn_t          spec[2];
  int            k, next_free, last_m;
  int            n_checks, n_fail;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  logic [DW-1:0] exp_rdd[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic make_spec(input int o, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rdata);
    spec[o].we    = we;
    spec[o].addr  = addr;
    spec[o].wdata = wdata;
    spec[o].lat   = lat;
    spec[o].rdata = rdata;
  endtask

  // Requests raised at cycle s0 are served one at a time, the loser of a tie
  // going second; each access occupies the bus until its result returns.
  task automatic plan(input int s0, input bit r0, input bit r1);
    int   order[$];
    int   t;
    txn_t x;
    if (r0 && r1) order = (last_m == 1) ? '{0, 1} : '{1, 0};
    else if (r0)  order = '{0};
    else if (r1)  order = '{1};
    t = s0;
    foreach (order[i]) begin
      x       = spec[order[i]];
      x.owner = order[i];
      x.start = s0;
      x.issue = t + 1;
      last_m  = x.owner;
      if (x.we) begin
        x.busy_end = x.issue;
        x.rdv      = -1;
        x.err      = 1'b0;
        t          = x.issue + 1;
      end else begin
        x.err      = !(x.lat >= 1 && x.lat <= T);
        x.busy_end = x.issue + (x.err ? T : x.lat);
        x.rdv      = x.busy_end + 1;
        t          = x.rdv;
      end
      txq.push_back(x);
    end
    next_free = t;
  endtask

  task automatic check_cycle();
    bit   e_gnt[2], e_rv[2], e_re[2];
    bit   e_wr, e_rd, e_busy;
    txn_t t;
    e_gnt = '{0, 0};
    e_rv  = '{0, 0};
    e_re  = '{0, 0};
    e_wr  = 0;
    e_rd  = 0;
    e_busy = 0;
    foreach (txq[i]) begin
      t = txq[i];
      if (k == t.issue) begin
        e_gnt[t.owner] = 1;
        if (t.we) e_wr = 1; else e_rd = 1;
        exp_addr = t.addr;
        exp_wd   = t.we ? t.wdata : '0;
      end
      if (k >= t.issue && k <= t.busy_end) e_busy = 1;
      if (!t.we && k == t.rdv) begin
        e_rv[t.owner]    = 1;
        e_re[t.owner]    = t.err;
        exp_rdd[t.owner] = t.err ? '0 : t.rdata;
      end
    end
    check("gnt0",      32'(gnt0),      32'(e_gnt[0]));
    check("gnt1",      32'(gnt1),      32'(e_gnt[1]));
    check("WrEn",      32'(WrEn),      32'(e_wr));
    check("RdEn",      32'(RdEn),      32'(e_rd));
    check("busy",      32'(busy),      32'(e_busy));
    check("Address",   32'(Address),   32'(exp_addr));
    check("WrData",    32'(WrData),    32'(exp_wd));
    check("rd_valid0", 32'(rd_valid0), 32'(e_rv[0]));
    check("rd_valid1", 32'(rd_valid1), 32'(e_rv[1]));
    check("rd_err0",   32'(rd_err0),   32'(e_re[0]));
    check("rd_err1",   32'(rd_err1),   32'(e_re[1]));
    check("rd_data0",  32'(rd_data0),  32'(exp_rdd[0]));
    check("rd_data1",  32'(rd_data1),  32'(exp_rdd[1]));
  endtask

  task automatic drive_cycle();
    bit   v, in_wait;
    txn_t t;
    req0 = 1'b0; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
    req1 = 1'b0; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
    v       = 0;
    in_wait = 0;
    RdData  = DW'($urandom);
    foreach (txq[i]) begin
      t = txq[i];
      // A requester holds its command through the cycle in which it sees gnt.
      if (k >= t.start && k <= t.issue) begin
        if (t.owner == 0) begin
          req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata;
        end else begin
          req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata;
        end
      end
      if (!t.we) begin
        if (t.lat >= 1 && k == t.issue + t.lat) begin
          v      = 1;
          RdData = t.rdata;
        end
        if (k > t.issue && k <= t.busy_end) in_wait = 1;
      end
    end
    // Stray valids only where no read is waiting; they must be ignored.
    if (!v && !in_wait && $urandom_range(3) == 0) v = 1;
    RdData_Valid = v;
  endtask

  task automatic do_cycle();
    @(negedge CLK);
    check_cycle();
    drive_cycle();
    while (txq.size() > 0 && txq[0].issue + T + 4 < k) void'(txq.pop_front());
    k++;
  endtask

  task automatic run_until(input int stop);
    while (k < stop) do_cycle();
  endtask

  task automatic model_reset();
    txq.delete();
    last_m     = 1;
    exp_addr   = '0;
    exp_wd     = '0;
    exp_rdd[0] = '0;
    exp_rdd[1] = '0;
  endtask

  initial begin
    bit r0, r1;
    n_checks = 0;
    n_fail   = 0;
    k        = 0;
    model_reset();
    repeat (2) @(negedge CLK);
    check_cycle();
    RST       = 1'b1;
    next_free = 0;

    make_spec(0, 1, 4'h5, 8'hA5, 0, 8'h00);
    plan(k, 1, 0);
    run_until(next_free);

    make_spec(1, 0, 4'h3, 8'h00, 1, 8'h3C);
    plan(k, 0, 1);
    run_until(next_free);

    repeat (3) begin
      make_spec(0, 1, AW'($urandom), DW'($urandom), 0, 8'h00);
      make_spec(1, 1, AW'($urandom), DW'($urandom), 0, 8'h00);
      plan(k, 1, 1);
      run_until(next_free);
    end

    make_spec(0, 0, 4'h9, 8'h00, 0, 8'h00);
    make_spec(1, 1, 4'h2, 8'h77, 0, 8'h00);
    plan(k, 1, 1);
    run_until(next_free);

    make_spec(1, 0, 4'hC, 8'h00, T, 8'h5A);
    plan(k, 0, 1);
    run_until(next_free);

    make_spec(0, 0, 4'h1, 8'h00, T + 1, 8'h99);
    plan(k, 1, 0);
    run_until(next_free);

    repeat (150) begin
      run_until(next_free + int'($urandom_range(2)));
      for (int o = 0; o < 2; o++)
        make_spec(o, 1'($urandom), AW'($urandom), DW'($urandom),
                  int'($urandom_range(T + 2)), DW'($urandom));
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      plan(k, r0, r1);
      run_until(next_free);
    end

    // Abort a read in flight, then confirm the pointer favours requester 0 again.
    make_spec(0, 0, 4'hE, 8'h00, 0, 8'h00);
    plan(k, 1, 0);
    run_until(txq[$].issue + 4);
    #1;
    RST  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    RdData_Valid = 1'b0;
    model_reset();
    #1;
    check_cycle();
    @(negedge CLK);
    check_cycle();
    RST       = 1'b1;
    k         = 0;
    make_spec(0, 1, 4'h7, 8'h11, 0, 8'h00);
    make_spec(1, 1, 4'h8, 8'h22, 0, 8'h00);
    plan(0, 1, 1);
    run_until(next_free + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
